// File: rtl/cpu_run_controller.sv
// Run-and-dump sequencer for the R-type pipelined CPU.
// It feeds the CPU its own next address until the last instruction, holds the
// PC while the pipeline drains, then streams every register-file word out
// over a valid/ready handshake.
module cpu_run_controller #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int INSTR_MAX    = 128,
    parameter int INSTR_STEP   = 4,
    parameter int REG_MAX      = 32,
    parameter int DRAIN_CYCLES = 5,
    parameter int MAX_CYCLES   = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          pc_in,
    output logic [ADDR_W-1:0]          pc_out,
    output logic                       cpu_en,
    output logic [$clog2(REG_MAX)-1:0] rf_raddr,
    input  logic [DATA_W-1:0]          rf_rdata,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [DATA_W-1:0]          dump_data,
    output logic [$clog2(REG_MAX)-1:0] dump_index,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [CNT_W-1:0]           cycle_count
);

    localparam int IDX_W = $clog2(REG_MAX);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(INSTR_MAX - INSTR_STEP);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(REG_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_LOAD,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DRN_W-1:0]  drain_cnt;
    logic [DRN_W-1:0]  drain_cnt_n;
    logic [ADDR_W-1:0] pc_n;
    logic [IDX_W-1:0]  idx_n;
    logic [DATA_W-1:0] data_n;
    logic [IDX_W-1:0]  dix_n;
    logic              valid_n;
    logic              timeout_n;
    logic [CNT_W-1:0]  count_n;

    // Cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // State and datapath registers; status flags decode the upcoming state so
    // they are registered yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            pc_out      <= '0;
            rf_raddr    <= '0;
            dump_data   <= '0;
            dump_index  <= '0;
            dump_valid  <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            cpu_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            drain_cnt   <= drain_cnt_n;
            pc_out      <= pc_n;
            rf_raddr    <= idx_n;
            dump_data   <= data_n;
            dump_index  <= dix_n;
            dump_valid  <= valid_n;
            timeout     <= timeout_n;
            cycle_count <= count_n;
            cpu_en      <= (state_n == S_RUN) || (state_n == S_DRAIN);
            busy        <= (state_n == S_RUN) || (state_n == S_DRAIN) ||
                           (state_n == S_LOAD) || (state_n == S_OUT);
            done        <= (state_n == S_DONE);
        end
    end

    // Next-state and next-register values; everything holds unless a state
    // explicitly updates it. rf_raddr doubles as the dump word index.
    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        pc_n        = pc_out;
        idx_n       = rf_raddr;
        data_n      = dump_data;
        dix_n       = dump_index;
        valid_n     = dump_valid;
        timeout_n   = timeout;
        count_n     = cycle_count;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n     = S_RUN;
                    pc_n        = '0;
                    count_n     = '0;
                    timeout_n   = 1'b0;
                    drain_cnt_n = '0;
                    idx_n       = '0;
                end
            end
            S_RUN: begin
                count_n = sat_inc(cycle_count);
                // End check looks at the address already presented to the CPU,
                // so an overshooting pc_in is loaded once before draining.
                if (pc_out >= END_ADDR) begin
                    state_n = S_DRAIN;
                end else if (cycle_count == TMO_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = S_DRAIN;
                end else begin
                    pc_n = pc_in;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRN_LAST) begin
                    state_n = S_LOAD;
                end else begin
                    drain_cnt_n = drain_cnt + DRN_W'(1);
                end
            end
            S_LOAD: begin
                data_n  = rf_rdata;
                dix_n   = rf_raddr;
                valid_n = 1'b1;
                state_n = S_OUT;
            end
            S_OUT: begin
                if (dump_ready) begin
                    valid_n = 1'b0;
                    if (rf_raddr == IDX_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = rf_raddr + IDX_W'(1);
                        state_n = S_LOAD;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: a CPU next-address model and a
// register-file array drive the DUT; expected PC traces, counts and the dump
// stream come from a high-level model of the run/drain/dump rules.
module tb_cpu_run_controller;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int REG_MAX  = 32;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 16;
    localparam int END_ADDR = 124;
    localparam int DRAIN    = 5;

    int n_checks = 0;
    int n_pass   = 0;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic dump_ready;

    // Main instance (default parameters)
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] pc_out;
    logic              cpu_en;
    logic [IDX_W-1:0]  rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic [IDX_W-1:0]  dump_index;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;

    // Short-timeout instance with a stuck CPU
    logic              start2;
    logic [ADDR_W-1:0] pc_in2;
    logic [ADDR_W-1:0] pc_out2;
    logic              cpu_en2;
    logic [IDX_W-1:0]  rf_raddr2;
    logic [DATA_W-1:0] rf_rdata2;
    logic              dump_valid2;
    logic              dump_ready2;
    logic [DATA_W-1:0] dump_data2;
    logic [IDX_W-1:0]  dump_index2;
    logic              busy2;
    logic              done2;
    logic              timeout2;
    logic [CNT_W-1:0]  cycle_count2;

    logic [DATA_W-1:0] regs [REG_MAX];
    int                stepmap [32];
    bit                cpu_mode;

    always #5 clk = ~clk;

    // CPU model: mode 0 steps by 4, mode 1 jumps by a per-address random step.
    always_comb begin
        pc_in = pc_out + (cpu_mode ? ADDR_W'(stepmap[pc_out[6:2]] * 4) : ADDR_W'(4));
    end

    assign rf_rdata    = regs[rf_raddr];
    assign rf_rdata2   = regs[rf_raddr2];
    assign pc_in2      = ADDR_W'(8);
    assign dump_ready2 = 1'b1;

    cpu_run_controller dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .pc_out(pc_out),
        .cpu_en(cpu_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_index(dump_index), .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    cpu_run_controller #(.MAX_CYCLES(20)) dut_t (
        .clk(clk), .rst(rst), .start(start2), .pc_in(pc_in2), .pc_out(pc_out2),
        .cpu_en(cpu_en2), .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2),
        .dump_valid(dump_valid2), .dump_ready(dump_ready2), .dump_data(dump_data2),
        .dump_index(dump_index2), .busy(busy2), .done(done2), .timeout(timeout2),
        .cycle_count(cycle_count2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start pulse, RUN trace against the modelled address sequence, then DRAIN.
    task automatic run_phase(input bit poke_start);
        int pcs[$];
        int p;
        pcs.delete();
        p = 0;
        forever begin
            pcs.push_back(p);
            if (p >= END_ADDR) break;
            p = p + (cpu_mode ? stepmap[(p >> 2) & 31] * 4 : 4);
        end

        start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++;
        if (pc_out !== 0 || cycle_count !== 0 || timeout !== 1'b0 || cpu_en !== 1'b1 ||
            busy !== 1'b1 || done !== 1'b0)
            $display("FAIL start_entry: pc=%0d cnt=%0d to=%b en=%b busy=%b done=%b, need 0 0 0 1 1 0",
                     pc_out, cycle_count, timeout, cpu_en, busy, done);
        else n_pass++;

        for (int k = 0; k < pcs.size(); k++) begin
            n_checks++;
            if (pc_out !== pcs[k] || cycle_count !== k || cpu_en !== 1'b1)
                $display("FAIL run_trace[%0d]: pc=%0d cnt=%0d en=%b, need pc=%0d cnt=%0d en=1",
                         k, pc_out, cycle_count, cpu_en, pcs[k], k);
            else n_pass++;
            if (poke_start && k == 2) start = 1'b1;
            tick;
            start = 1'b0;
        end

        n_checks++;
        if (cycle_count !== pcs.size() || pc_out !== pcs[pcs.size()-1] || timeout !== 1'b0)
            $display("FAIL run_end: cnt=%0d pc=%0d to=%b, need cnt=%0d pc=%0d to=0",
                     cycle_count, pc_out, timeout, pcs.size(), pcs[pcs.size()-1]);
        else n_pass++;

        for (int d = 0; d < DRAIN; d++) begin
            n_checks++;
            if (cpu_en !== 1'b1 || busy !== 1'b1 || dump_valid !== 1'b0 ||
                pc_out !== pcs[pcs.size()-1])
                $display("FAIL drain[%0d]: en=%b busy=%b vld=%b pc=%0d, need 1 1 0 pc=%0d",
                         d, cpu_en, busy, dump_valid, pc_out, pcs[pcs.size()-1]);
            else n_pass++;
            if (poke_start && d == 1) start = 1'b1;
            tick;
            start = 1'b0;
        end

        n_checks++;
        if (cpu_en !== 1'b0 || busy !== 1'b1 || dump_valid !== 1'b0 || rf_raddr !== 0)
            $display("FAIL load_entry: en=%b busy=%b vld=%b raddr=%0d, need 0 1 0 0",
                     cpu_en, busy, dump_valid, rf_raddr);
        else n_pass++;
    endtask

    // Dump stream: mode 0 ready=1, mode 1 random ready, mode 2 stall word 7 for 3 cycles.
    task automatic dump_phase(input int mode, input bit start_on_last, output int cycles);
        int exp_idx;
        int stall;
        int acc7;
        bit prev_hold;
        logic [DATA_W-1:0] prev_data;
        logic [IDX_W-1:0]  prev_idx;
        logic [CNT_W-1:0]  cnt_keep;
        exp_idx   = 0;
        stall     = 0;
        acc7      = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_idx  = '0;
        cycles    = 0;
        cnt_keep  = cycle_count;
        while (done !== 1'b1 && cycles < 400) begin
            if (prev_hold) begin
                n_checks++;
                if (dump_valid !== 1'b1 || dump_data !== prev_data || dump_index !== prev_idx)
                    $display("FAIL hold_stable: vld=%b data=%h idx=%0d, need 1 %h %0d",
                             dump_valid, dump_data, dump_index, prev_data, prev_idx);
                else n_pass++;
            end
            case (mode)
                0: dump_ready = 1'b1;
                1: dump_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (dump_valid && dump_index == 7 && stall < 3) begin
                        dump_ready = 1'b0;
                        stall++;
                    end else begin
                        dump_ready = 1'b1;
                    end
                end
            endcase
            if (dump_valid === 1'b1 && dump_ready) begin
                n_checks++;
                if (exp_idx >= REG_MAX)
                    $display("FAIL extra_word: idx=%0d data=%h, need no word", dump_index, dump_data);
                else if (dump_index !== IDX_W'(exp_idx) || dump_data !== regs[exp_idx])
                    $display("FAIL word[%0d]: idx=%0d data=%h, need idx=%0d data=%h",
                             exp_idx, dump_index, dump_data, exp_idx, regs[exp_idx]);
                else n_pass++;
                if (dump_index == 7) acc7++;
                exp_idx++;
                if (start_on_last && exp_idx == REG_MAX) start = 1'b1;
            end
            prev_hold = dump_valid && !dump_ready;
            prev_data = dump_data;
            prev_idx  = dump_index;
            tick;
            start = 1'b0;
            cycles++;
        end
        dump_ready = 1'b0;

        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0 || exp_idx !== REG_MAX)
            $display("FAIL dump_end: done=%b busy=%b vld=%b words=%0d, need 1 0 0 %0d",
                     done, busy, dump_valid, exp_idx, REG_MAX);
        else n_pass++;

        if (mode == 2) begin
            n_checks++;
            if (acc7 !== 1 || stall !== 3)
                $display("FAIL word7_once: accepts=%0d stalls=%0d, need 1 3", acc7, stall);
            else n_pass++;
        end

        if (start_on_last) begin
            tick;
            n_checks++;
            if (done !== 1'b1 || cpu_en !== 1'b0 || cycle_count !== cnt_keep)
                $display("FAIL start_on_last_accept: done=%b en=%b cnt=%0d, need 1 0 %0d",
                         done, cpu_en, cycle_count, cnt_keep);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        start      = 1'b0;
        start2     = 1'b0;
        dump_ready = 1'b0;
        cpu_mode   = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        n_checks++;
        if (pc_out !== 0 || cycle_count !== 0 || rf_raddr !== 0 || dump_data !== 0 ||
            dump_index !== 0)
            $display("FAIL reset_data: pc=%0d cnt=%0d raddr=%0d data=%h idx=%0d, need all 0",
                     pc_out, cycle_count, rf_raddr, dump_data, dump_index);
        else n_pass++;
        n_checks++;
        if ({cpu_en, dump_valid, busy, done, timeout} !== 5'b0)
            $display("FAIL reset_flags: en/vld/busy/done/to=%b, need 00000",
                     {cpu_en, dump_valid, busy, done, timeout});
        else n_pass++;
        tick;
        n_checks++;
        if (busy !== 1'b0 || cpu_en !== 1'b0)
            $display("FAIL idle_stays: busy=%b en=%b, need 0 0", busy, cpu_en);
        else n_pass++;
    endtask

    task automatic test_run_basic;
        int cyc;
        for (int i = 0; i < REG_MAX; i++) regs[i] = DATA_W'(i * 'h11);
        cpu_mode = 1'b0;
        run_phase(1'b1);
        dump_phase(0, 1'b1, cyc);
        n_checks++;
        if (cyc !== 64)
            $display("FAIL load_to_done_cycles: got %0d, need 64", cyc);
        else n_pass++;
    endtask

    task automatic test_done_restart;
        int cyc;
        tick;
        tick;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pc_out !== END_ADDR || cycle_count !== 32 ||
            timeout !== 1'b0)
            $display("FAIL done_hold: done=%b busy=%b pc=%0d cnt=%0d to=%b, need 1 0 124 32 0",
                     done, busy, pc_out, cycle_count, timeout);
        else n_pass++;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < REG_MAX; i++) regs[i] = $urandom;
            for (int i = 0; i < 32; i++) stepmap[i] = $urandom_range(1, 3);
            cpu_mode = 1'b1;
            run_phase(1'b0);
            dump_phase(1, 1'b0, cyc);
        end
        cpu_mode = 1'b0;
    endtask

    task automatic test_backpressure;
        int cyc;
        for (int i = 0; i < REG_MAX; i++) regs[i] = DATA_W'(i * 'h11);
        cpu_mode = 1'b0;
        run_phase(1'b0);
        dump_phase(2, 1'b0, cyc);
        n_checks++;
        if (cyc !== 67)
            $display("FAIL stall_cycles: got %0d, need 67", cyc);
        else n_pass++;
    endtask

    task automatic test_stuck_pc;
        int words;
        int cyc;
        for (int i = 0; i < REG_MAX; i++) regs[i] = DATA_W'(i * 'h11);
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (timeout2 !== 1'b0 || cpu_en2 !== 1'b1 || pc_out2 !== (k == 0 ? 0 : 8))
                $display("FAIL stuck_run[%0d]: to=%b en=%b pc=%0d, need 0 1 %0d",
                         k, timeout2, cpu_en2, pc_out2, (k == 0 ? 0 : 8));
            else n_pass++;
            tick;
        end
        n_checks++;
        if (timeout2 !== 1'b1 || cycle_count2 !== 20 || pc_out2 !== 8 || cpu_en2 !== 1'b1)
            $display("FAIL stuck_timeout: to=%b cnt=%0d pc=%0d en=%b, need 1 20 8 1",
                     timeout2, cycle_count2, pc_out2, cpu_en2);
        else n_pass++;
        repeat (DRAIN) tick;
        n_checks++;
        if (cpu_en2 !== 1'b0 || busy2 !== 1'b1)
            $display("FAIL stuck_load: en=%b busy=%b, need 0 1", cpu_en2, busy2);
        else n_pass++;
        words = 0;
        cyc   = 0;
        while (done2 !== 1'b1 && cyc < 300) begin
            if (dump_valid2 === 1'b1) begin
                n_checks++;
                if (dump_index2 !== IDX_W'(words) || dump_data2 !== regs[words % REG_MAX])
                    $display("FAIL stuck_word[%0d]: idx=%0d data=%h, need %0d %h",
                             words, dump_index2, dump_data2, words, regs[words % REG_MAX]);
                else n_pass++;
                words++;
            end
            tick;
            cyc++;
        end
        n_checks++;
        if (done2 !== 1'b1 || words !== REG_MAX || timeout2 !== 1'b1)
            $display("FAIL stuck_done: done=%b words=%0d to=%b, need 1 %0d 1",
                     done2, words, timeout2, REG_MAX);
        else n_pass++;
    endtask

    task automatic test_reset_mid_dump;
        int n;
        int cyc;
        for (int i = 0; i < REG_MAX; i++) regs[i] = $urandom;
        cpu_mode = 1'b0;
        run_phase(1'b0);
        n = 0;
        while (!(dump_valid === 1'b1 && dump_index == 10) && n < 100) begin
            dump_ready = 1'b1;
            tick;
            n++;
        end
        dump_ready = 1'b0;
        n_checks++;
        if (dump_valid !== 1'b1 || dump_index !== 10)
            $display("FAIL reach_word10: vld=%b idx=%0d, need 1 10", dump_valid, dump_index);
        else n_pass++;
        rst        = 1'b1;
        dump_ready = 1'b1;
        start      = 1'b1;
        tick;
        rst        = 1'b0;
        dump_ready = 1'b0;
        start      = 1'b0;
        n_checks++;
        if ({cpu_en, dump_valid, busy, done, timeout} !== 5'b0 || pc_out !== 0 ||
            cycle_count !== 0 || rf_raddr !== 0 || dump_data !== 0 || dump_index !== 0)
            $display("FAIL abort_reset: flags=%b pc=%0d cnt=%0d raddr=%0d data=%h idx=%0d, need all 0",
                     {cpu_en, dump_valid, busy, done, timeout}, pc_out, cycle_count,
                     rf_raddr, dump_data, dump_index);
        else n_pass++;
        run_phase(1'b0);
        dump_phase(0, 1'b0, cyc);
    endtask

    initial begin
        test_reset;
        test_run_basic;
        test_done_restart;
        test_backpressure;
        test_stuck_pc;
        test_reset_mid_dump;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Synthesizable run-and-dump sequencer for the R-type pipelined CPU. It drives the CPU fetch address from the CPU's own next-address output until the program end. It then holds the PC while the pipeline drains. Finally it reads out every register-file word over a valid/ready stream. It generalises the bench-level fetch loop with parametrised memory size, address step, register count, drain depth and timeout, and adds start/done/handshake control.

Parameters:
ADDR_W, 32, width of instruction addresses
DATA_W, 32, register-file word width
INSTR_MAX, 128, instruction memory size in bytes
INSTR_STEP, 4, bytes per instruction; END_ADDR = INSTR_MAX - INSTR_STEP
REG_MAX, 32, number of registers dumped (>= 2)
DRAIN_CYCLES, 5, cycles PC is held after END_ADDR (>= 1)
MAX_CYCLES, 1024, RUN-cycle timeout
CNT_W, 16, cycle counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle start pulse; sampled only in IDLE or DONE
pc_in  in  ADDR_W  CPU next address (CPU Output_Addr)
pc_out  out  ADDR_W  CPU fetch address (CPU Input_Addr)
cpu_en  out  1  high while CPU must advance (RUN, DRAIN)
rf_raddr  out  $clog2(REG_MAX)  register-file dump read address
rf_rdata  in  DATA_W  register-file data; combinational on rf_raddr
dump_valid  out  1  dump_data/dump_index valid
dump_ready  in  1  consumer accepts the word when valid&&ready on a rising edge
dump_data  out  DATA_W  dumped register value
dump_index  out  $clog2(REG_MAX)  index of dump_data
busy  out  1  high in RUN, DRAIN, LOAD, OUT
done  out  1  high in DONE
timeout  out  1  sticky; set when RUN hit MAX_CYCLES
cycle_count  out  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- Reset (any state): state=IDLE. pc_out=0, rf_raddr=0, dump_data=0, dump_index=0. cpu_en, dump_valid, busy, done and timeout all 0. cycle_count=0.
- States: IDLE, RUN, DRAIN, LOAD, OUT, DONE. All outputs are registered.
- IDLE/DONE, start=1 -> RUN:
  - pc_out<=0, cycle_count<=0, timeout<=0, drain counter<=0, index<=0.
  - start is ignored in every other state.
- RUN (cpu_en=1):
  - Each cycle, cycle_count increments, saturating at 2^CNT_W-1.
  - If pc_out >= END_ADDR (unsigned) -> DRAIN, with pc_out held.
  - Else if cycle_count == MAX_CYCLES-1 -> timeout<=1, DRAIN, with pc_out held.
  - Else pc_out<=pc_in (one-cycle feedback latency).
  - The end check uses the registered pc_out. A pc_in beyond INSTR_MAX is still loaded and then triggers DRAIN next cycle.
- DRAIN (cpu_en=1, pc_out frozen):
  - Lasts exactly DRAIN_CYCLES cycles via the drain counter, then -> LOAD.
- LOAD (cpu_en=0):
  - rf_raddr=index.
  - On the edge: dump_data<=rf_rdata, dump_index<=index, dump_valid<=1 -> OUT.
- OUT:
  - dump_valid, dump_data and dump_index are held stable until dump_ready.
  - On valid&&ready: dump_valid<=0.
  - If index==REG_MAX-1 -> DONE, else index<=index+1 -> LOAD.
  - Peak throughput is 1 word per 2 cycles. There is no wrap-around of index.
- DONE: done=1, busy=0. pc_out, cycle_count and timeout hold their values.
- Simultaneous events:
  - rst dominates start and dump_ready.
  - start in the same cycle as the last accept is ignored, because the state is still OUT.
- Reset mid-dump aborts the stream: dump_valid=0 on the next cycle, with no partial-word handshake.

Test Plan:
- Reset, start. CPU model returns pc_in=pc_out+4, with INSTR_MAX=128 -> pc_out is 0,4,…,124. DRAIN begins the cycle after pc_out=124. cycle_count=32. DRAIN lasts 5 cycles with cpu_en=1.
- Dump with dump_ready tied 1 and R[i]=i*0x11 -> 32 words with dump_index 0..31 and dump_data i*0x11. There are 64 cycles from the first LOAD to DONE. done=1 and busy=0 afterwards.
- Backpressure: dump_ready=0 for 3 cycles on word 7 -> dump_valid stays 1 and dump_data=0x77 is stable. Word 7 is accepted exactly once and word 8 follows.
- Stuck PC: pc_in always 8, with MAX_CYCLES=20 -> timeout=1 after 20 RUN cycles. Then DRAIN, then the full 32-word dump, then done=1.
- Reset asserted during OUT of word 10 -> next cycle state IDLE, all outputs at reset values. A following start restarts from pc_out=0 with timeout=0.
- start pulsed during RUN and DRAIN -> no effect. start in DONE -> rerun with cycle_count cleared and dump_index restarting at 0.
